mem_port_arbiter: RTL and testbench

- Shares one variable-latency backing memory port (the MemoryController request/ready interface) between the instruction-fetch requester (I, read-only) and the data-memory requester (D, read/write).
- Sits between the fetch/memory pipeline stages and the memory controller.
- Arbitrates with fixed D priority plus an anti-starvation cap.
- Registers all backing-port outputs and returns one-cycle ready pulses to the winning requester.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch (I) and data (D)
// requesters; D has fixed priority, capped by a streak limit while I is waiting.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [2:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            grant
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state;
  logic [SW-1:0] streak;
  logic d_win, i_win;
  always_comb begin
    d_win = d_req && !(i_req && streak == SW'(MAX_D_STREAK));
    i_win = !d_win && i_req;
  end
  // A D grant with i_req high implies streak < MAX_D_STREAK, so the increment never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      streak <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_size <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      grant <= 2'b00;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            state <= SERVE_D;
            grant <= 2'b10;
            mem_req <= 1'b1;
            mem_we <= d_we;
            mem_size <= d_size;
            mem_addr <= d_addr;
            mem_wdata <= d_wdata;
            streak <= i_req ? streak + 1'b1 : '0;
          end else if (i_win) begin
            state <= SERVE_I;
            grant <= 2'b01;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_size <= 3'b010;
            mem_addr <= i_addr;
            mem_wdata <= '0;
            streak <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_ready) begin
            state <= IDLE;
            grant <= 2'b00;
            mem_req <= 1'b0;
            if (state == SERVE_I) begin
              i_ready <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner sequences, ready pulses scored against a queue.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst;
  logic i_req, i_ready, d_req, d_we, d_ready, mem_req, mem_we, mem_ready;
  logic [16:0] i_addr, d_addr, mem_addr;
  logic [31:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [2:0] d_size, mem_size;
  logic [1:0] grant;
  int vec_cnt = 0, err_cnt = 0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [2:0]  size;
    logic [16:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        drop;
    logic        e_we;
    logic [2:0]  e_size;
    logic [31:0] e_wdata;
  } vec_t;
  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;
  vec_t tbl[7];
  exp_t exp_q[$];
  exp_t sb_e;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [16:0] a);
    return a == 17'h00010 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  assign mem_rdata = rd(mem_addr);

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
  );

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    vec_cnt++;
    if (a !== e) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (i_ready || d_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL sb_unexpected: i_ready=%b d_ready=%b expected no pulse", i_ready, d_ready);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_port", {i_ready, d_ready}, sb_e.is_d ? 2'b01 : 2'b10);
        check("sb_rdata", sb_e.is_d ? d_rdata : i_rdata, sb_e.rdata);
      end
    end
  end

  task automatic check_port(input vec_t v);
    check("mem_req", mem_req, 1'b1);
    check("mem_addr", mem_addr, v.addr);
    check("mem_we", mem_we, v.e_we);
    check("mem_size", mem_size, v.e_size);
    check("mem_wdata", mem_wdata, v.e_wdata);
    check("grant", grant, v.is_d ? 2'b10 : 2'b01);
  endtask

  task automatic run_txn(input vec_t v);
    logic [31:0] other;
    other = v.is_d ? i_rdata : d_rdata;
    exp_q.push_back('{v.is_d, rd(v.addr)});
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check_port(v);
    if (v.drop) begin
      d_req = 1'b0; i_req = 1'b0; d_addr = ~v.addr; i_addr = ~v.addr; d_wdata = 32'h0;
    end
    for (int w = 0; w <= v.waits; w++) begin
      mem_ready = (w == v.waits);
      @(posedge clk); #1;
      if (w < v.waits) check_port(v);
    end
    mem_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;
    check("ready_pulse", {i_ready, d_ready}, v.is_d ? 2'b01 : 2'b10);
    check("other_rdata_hold", v.is_d ? i_rdata : d_rdata, other);
    check("mem_req_drop", mem_req, 1'b0);
    @(posedge clk); #1;
    check("ready_low", {i_ready, d_ready}, 2'b00);
  endtask

  initial begin
    int n;
    vec_t iv;
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0;
    d_wdata = 0; mem_ready = 0;
    tbl[0] = '{1'b0, 1'b0, 3'b000, 17'h00010, 32'h0, 0, 1'b0, 1'b0, 3'b010, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 3'b000, 17'h1F004, 32'hA5, 3, 1'b0, 1'b1, 3'b000, 32'hA5};
    tbl[2] = '{1'b1, 1'b0, 3'b010, 17'h00800, 32'h12345678, 1, 1'b0, 1'b0, 3'b010, 32'h12345678};
    tbl[3] = '{1'b0, 1'b1, 3'b111, 17'h1FFFC, 32'hFFFF, 2, 1'b0, 1'b0, 3'b010, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 3'b001, 17'h00444, 32'hCAFEF00D, 2, 1'b1, 1'b1, 3'b001, 32'hCAFEF00D};
    tbl[5] = '{1'b1, 1'b1, 3'b111, 17'h1FFFF, 32'h0BADCAFE, 0, 1'b0, 1'b1, 3'b111, 32'h0BADCAFE};
    tbl[6] = '{1'b0, 1'b0, 3'b000, 17'h00020, 32'h0, 1, 1'b1, 1'b0, 3'b010, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem", {mem_req, mem_we, mem_size, mem_addr, mem_wdata}, 0);
    check("rst_grant", grant, 2'b00);
    check("rst_ready", {i_ready, d_ready}, 2'b00);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) run_txn(tbl[k]);

    // contention: both held, D may win at most 4 times in a row
    i_addr = 17'h00200; d_addr = 17'h00100; d_we = 1'b0; d_size = 3'b010; d_wdata = 32'h0;
    for (int k = 0; k < 10; k++)
      exp_q.push_back('{(k % 5) != 4, rd((k % 5) == 4 ? 17'h00200 : 17'h00100)});
    i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(posedge clk); #1;
      if (i_ready || d_ready) n++;
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    check("contention_count", n, 10);
    @(posedge clk); #1;
    check("contention_idle", grant, 2'b00);

    // reset in the middle of an I access, together with mem_ready
    i_req = 1'b1; i_addr = 17'h00040;
    @(posedge clk); #1;
    check("midrst_grant_i", grant, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b1; i_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_grant", grant, 2'b00);
    check("midrst_ready", {i_ready, d_ready}, 2'b00);
    check("midrst_rdata", i_rdata, 32'h0);
    iv = '{1'b0, 1'b0, 3'b000, 17'h00040, 32'h0, 0, 1'b0, 1'b0, 3'b010, 32'h0};
    run_txn(iv);

    // spurious mem_ready while idle
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("spur_grant", grant, 2'b00);
      check("spur_ready", {i_ready, d_ready, mem_req}, 3'b000);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
